// File: rtl/boe_driver.sv
// boe_driver: collects a 2..6 byte packet from the host, streams it into an
// attached BOE engine, forwards the engine's sum/max/sorted results as
// one-cycle beats and self-checks them against a locally computed reference.
module boe_driver (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        boe_rst,
  output logic [2:0]  boe_data_num,
  output logic [7:0]  boe_data_in,
  input  logic [10:0] boe_result,
  output logic        out_valid,
  output logic [10:0] out_data,
  output logic [1:0]  out_tag,
  output logic        out_last,
  output logic        len_err,
  output logic        chk_err
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] TAG_SUM  = 2'd0;
  localparam logic [1:0] TAG_MAX  = 2'd1;
  localparam logic [1:0] TAG_SORT = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_count;
  logic [3:0]  r_cyc;
  logic [2:0]  r_n;
  logic [7:0]  r_buf [0:5];
  logic        r_out_valid;
  logic [10:0] r_out_data;
  logic [1:0]  r_out_tag;
  logic        r_out_last;
  logic        r_len_err;
  logic        r_chk_err;
  logic        r_bad;
  logic [7:0]  r_prev;

  logic        w_accept;
  logic [2:0]  w_total;
  logic        w_len_ok;
  logic [10:0] w_ref_sum;
  logic [7:0]  w_ref_max;
  logic [7:0]  w_data_sel;
  logic [3:0]  w_cyc_sum;
  logic [3:0]  w_cyc_max;
  logic [3:0]  w_cyc_s0;
  logic [3:0]  w_cyc_last;
  logic [7:0]  w_res_lo;
  logic        w_res_hi;
  logic        w_sort_bad;

  assign w_accept  = in_valid && (r_state == ST_LOAD);
  assign w_total   = (r_count == 3'd7) ? 3'd7 : r_count + 3'd1;
  assign w_len_ok  = (w_total >= 3'd2) && (w_total <= 3'd6);

  // Result bus is sampled one cycle before the beat becomes visible, so the
  // sample points are n, n+1, n+2..2n+1 on the cyc counter.
  assign w_cyc_sum  = {1'b0, r_n};
  assign w_cyc_max  = w_cyc_sum + 4'd1;
  assign w_cyc_s0   = w_cyc_sum + 4'd2;
  assign w_cyc_last = {r_n, 1'b0} + 4'd1;

  assign w_res_lo   = boe_result[7:0];
  assign w_res_hi   = |boe_result[10:8];
  assign w_sort_bad = w_res_hi ||
                      ((r_cyc == w_cyc_s0) ? (w_res_lo != r_prev) : (w_res_lo > r_prev));

  assign in_ready     = (r_state == ST_LOAD);
  assign boe_rst      = (r_state != ST_RUN);
  assign boe_data_num = r_n;
  assign boe_data_in  = ((r_state == ST_RUN) && (r_cyc < w_cyc_sum)) ? w_data_sel : '0;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_last  = r_out_last;
  assign len_err   = r_len_err;
  assign chk_err   = r_chk_err;

  // Reference sum/max over the first n buffer entries and the byte mux for cyc.
  always_comb begin
    w_ref_sum  = '0;
    w_ref_max  = '0;
    w_data_sel = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < 32'(r_n)) begin
        w_ref_sum = w_ref_sum + 11'(r_buf[i]);
        if (r_buf[i] > w_ref_max) w_ref_max = r_buf[i];
      end
      if (32'(r_cyc) == i) w_data_sel = r_buf[i];
    end
  end

  // Packet buffer: only the first six accepted beats are stored, no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && (r_count < 3'd6)) begin
      r_buf[r_count] <= in_data;
    end
  end

  // Control FSM, result capture and self-check.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_count     <= '0;
      r_cyc       <= '0;
      r_n         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_last  <= 1'b0;
      r_len_err   <= 1'b0;
      r_chk_err   <= 1'b0;
      r_bad       <= 1'b0;
      r_prev      <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_len_err   <= 1'b0;
      r_chk_err   <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (in_last) begin
              r_count <= '0;
              if (w_len_ok) begin
                r_n     <= w_total;
                r_cyc   <= '0;
                r_bad   <= 1'b0;
                r_state <= ST_RUN;
              end else begin
                r_len_err <= 1'b1;
              end
            end else begin
              r_count <= w_total;
            end
          end
        end
        ST_RUN: begin
          r_cyc <= r_cyc + 4'd1;
          if (r_cyc == w_cyc_sum) begin
            r_out_valid <= 1'b1;
            r_out_data  <= boe_result;
            r_out_tag   <= TAG_SUM;
            r_bad       <= r_bad || (boe_result != w_ref_sum);
          end else if (r_cyc == w_cyc_max) begin
            r_out_valid <= 1'b1;
            r_out_data  <= boe_result;
            r_out_tag   <= TAG_MAX;
            r_bad       <= r_bad || w_res_hi || (w_res_lo != w_ref_max);
            r_prev      <= w_res_lo;
          end else if ((r_cyc >= w_cyc_s0) && (r_cyc <= w_cyc_last)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= boe_result;
            r_out_tag   <= TAG_SORT;
            r_bad       <= r_bad || w_sort_bad;
            r_prev      <= w_res_lo;
            if (r_cyc == w_cyc_last) begin
              r_out_last <= 1'b1;
              r_chk_err  <= r_bad || w_sort_bad;
              r_state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_cyc   <= '0;
          r_state <= ST_LOAD;
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boe_driver.sv
// Directed self-checking bench for boe_driver with a programmable BOE stand-in.
module tb_boe_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        boe_rst;
  logic [2:0]  boe_data_num;
  logic [7:0]  boe_data_in;
  logic [10:0] boe_result;
  logic        out_valid;
  logic [10:0] out_data;
  logic [1:0]  out_tag;
  logic        out_last;
  logic        len_err;
  logic        chk_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  tx  [0:7];
  logic [10:0] exv [0:7];
  logic [10:0] seq [0:7];
  logic [7:0]  cap [0:7];
  logic [4:0]  bk;
  int          bidx;

  boe_driver dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .boe_rst      (boe_rst),
    .boe_data_num (boe_data_num),
    .boe_data_in  (boe_data_in),
    .boe_result   (boe_result),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .out_last     (out_last),
    .len_err      (len_err),
    .chk_err      (chk_err)
  );

  always #5 clk = ~clk;

  // BOE stand-in: counts cycles out of reset, captures n bytes, then replays seq.
  always @(posedge clk) begin
    if (boe_rst) begin
      bk <= '0;
    end else begin
      if (bk < 5'(boe_data_num)) cap[bk[2:0]] <= boe_data_in;
      if (bk != 5'd31) bk <= bk + 5'd1;
    end
  end

  always_comb begin
    boe_result = '0;
    bidx = int'(bk) - int'(boe_data_num);
    if (!boe_rst && bidx >= 0 && bidx <= int'(boe_data_num) + 1) boe_result = seq[bidx];
  end

  task automatic set_tx(input int d0 = 0, d1 = 0, d2 = 0, d3 = 0, d4 = 0, d5 = 0, d6 = 0);
    tx[0] = 8'(d0); tx[1] = 8'(d1); tx[2] = 8'(d2); tx[3] = 8'(d3);
    tx[4] = 8'(d4); tx[5] = 8'(d5); tx[6] = 8'(d6); tx[7] = '0;
  endtask

  task automatic set_exp(input int e0 = 0, e1 = 0, e2 = 0, e3 = 0, e4 = 0, e5 = 0, e6 = 0, e7 = 0);
    exv[0] = 11'(e0); exv[1] = 11'(e1); exv[2] = 11'(e2); exv[3] = 11'(e3);
    exv[4] = 11'(e4); exv[5] = 11'(e5); exv[6] = 11'(e6); exv[7] = 11'(e7);
    for (int i = 0; i < 8; i++) seq[i] = exv[i];
  endtask

  // Drives nb beats; returns at the negedge of the cycle after the last beat (t+1).
  task automatic send_beats(input int nb, input string nm);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s in_ready beat %0d: got %b want 1", nm, i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = tx[i];
      in_last  = (i == nb - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Checks cycles t+1..t+2n+3 after the in_last beat; returns at t+2n+3.
  task automatic collect(input int n, input logic exp_chk, input string nm);
    logic        ev, el, ec;
    logic [1:0]  et;
    logic [10:0] ed;
    for (int j = 1; j <= 2 * n + 3; j++) begin
      ev = (j >= n + 2);
      el = (j == 2 * n + 3);
      ec = el && exp_chk;
      et = (j == n + 2) ? 2'd0 : (j == n + 3) ? 2'd1 : 2'd2;
      ed = ev ? exv[j - n - 2] : '0;
      n_chk++;
      if (out_valid !== ev || (ev && (out_data !== ed || out_tag !== et || out_last !== el)) ||
          chk_err !== ec || len_err !== 1'b0 || in_ready !== 1'b0 || boe_rst !== el) begin
        n_fail++;
        $display("FAIL %s cycle t+%0d: got v=%b d=%0d tag=%0d last=%b chk=%b len=%b rdy=%b brst=%b want v=%b d=%0d tag=%0d last=%b chk=%b len=0 rdy=0 brst=%b",
                 nm, j, out_valid, out_data, out_tag, out_last, chk_err, len_err, in_ready, boe_rst,
                 ev, ed, et, el, ec, el);
      end
      if (j == 1) begin
        n_chk++;
        if (boe_data_num !== 3'(n)) begin
          n_fail++;
          $display("FAIL %s boe_data_num: got %0d want %0d", nm, boe_data_num, n);
        end
      end
      if (j < 2 * n + 3) @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (cap[i] !== tx[i]) begin
        n_fail++;
        $display("FAIL %s boe_data_in[%0d]: got %0d want %0d", nm, i, cap[i], tx[i]);
      end
    end
  endtask

  // m idle LOAD cycles: ready, BOE held in reset, nothing emitted.
  task automatic idle(input int m, input string nm);
    for (int j = 0; j < m; j++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || boe_rst !== 1'b1 || len_err !== 1'b0 || chk_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle %0d: got v=%b rdy=%b brst=%b len=%b chk=%b want 0 1 1 0 0",
                 nm, j, out_valid, in_ready, boe_rst, len_err, chk_err);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    set_tx(); set_exp();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({in_ready, boe_rst, boe_data_num, boe_data_in, out_valid, out_data, out_tag, out_last, len_err, chk_err}
        !== {1'b1, 1'b1, 3'd0, 8'd0, 1'b0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b brst=%b num=%0d din=%0d v=%b d=%0d tag=%0d last=%b len=%b chk=%b want 1 1 0 0 0 0 0 0 0 0",
               in_ready, boe_rst, boe_data_num, boe_data_in, out_valid, out_data, out_tag, out_last, len_err, chk_err);
    end
    rst = 1'b0;
    idle(2, "post_reset");
  endtask

  task automatic test_basic;
    set_tx(3, 7, 5); set_exp(15, 7, 7, 5, 3);
    send_beats(3, "basic");
    collect(3, 1'b0, "basic");
    idle(3, "basic");
  endtask

  task automatic test_full;
    set_tx(255, 255, 255, 255, 255, 255);
    set_exp(1530, 255, 255, 255, 255, 255, 255, 255);
    send_beats(6, "full");
    collect(6, 1'b0, "full");
    idle(2, "full");
  endtask

  task automatic test_len_err(input int nb, input string nm);
    set_tx(1, 2, 3, 4, 5, 6, 7); set_exp();
    send_beats(nb, nm);
    n_chk++;
    if (len_err !== 1'b1 || out_valid !== 1'b0 || boe_rst !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pulse: got len=%b v=%b brst=%b rdy=%b want 1 0 1 1", nm, len_err, out_valid, boe_rst, in_ready);
    end
    idle(6, nm);
  endtask

  task automatic test_chk_fail;
    set_tx(3, 7, 5); set_exp(14, 7, 7, 5, 3);
    send_beats(3, "chkfail");
    collect(3, 1'b1, "chkfail");
    idle(2, "chkfail");
  endtask

  task automatic test_back_to_back;
    set_tx(2, 9); set_exp(11, 9, 9, 2);
    send_beats(2, "b2b_a");
    collect(2, 1'b0, "b2b_a");
    set_tx(4, 4, 1, 8); set_exp(17, 8, 8, 4, 4, 1);
    send_beats(4, "b2b_b");
    collect(4, 1'b0, "b2b_b");
    idle(2, "b2b");
  endtask

  task automatic test_mid_reset;
    set_tx(1, 2, 3, 4, 5); set_exp(15, 5, 5, 4, 3, 2, 1);
    send_beats(5, "midrst");
    repeat (4) @(negedge clk);
    n_chk++;
    if (boe_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst running: got brst=%b want 0", boe_rst);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (boe_rst !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst after: got brst=%b rdy=%b v=%b want 1 1 0", boe_rst, in_ready, out_valid);
    end
    idle(12, "midrst");
    set_tx(3, 7, 5); set_exp(15, 7, 7, 5, 3);
    send_beats(3, "midrst_next");
    collect(3, 1'b0, "midrst_next");
    idle(2, "midrst_next");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_len_err(1, "len1");
    test_len_err(7, "len7");
    test_chk_fail();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
